stream_fifo: RTL and testbench

Parametrised synchronous FIFO with valid/ready handshakes on both sides, occupancy flags and a recirculate (loop) mode. It generalises the fixed 1-bit × 256 video memory to any width and power-of-two depth. It sits between the pixel source (LFSR or pattern generator) and the VGA controller, and holds line or pattern data. In loop mode it replays its stored contents indefinitely as a video pattern memory.

---
 rtl/stream_fifo_if.sv | 30 +++
 rtl/stream_fifo.sv | 93 +++++++++
 tb/tb_stream_fifo.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/stream_fifo_if.sv
// Handshake and status bundle for stream_fifo: write side, read side and occupancy flags.
// The FIFO connects through the slave modport; the producer/consumer side uses master.
interface stream_fifo_if #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 256
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, count, full, empty, almost_full, almost_empty
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, count, full, empty, almost_full, almost_empty
    );
endinterface

// File: rtl/stream_fifo.sv
// Synchronous first-word fall-through FIFO with valid/ready on both sides, occupancy flags
// and a loop mode that recirculates popped words so stored contents replay indefinitely.
module stream_fifo #(
    parameter int unsigned WIDTH      = 2,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned AFULL_LVL  = DEPTH - 4,
    parameter int unsigned AEMPTY_LVL = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          flush,
    input  logic          loop,
    stream_fifo_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic full, empty;
    logic in_ready, out_valid;
    logic push, pop;
    logic mem_we;
    logic [WIDTH-1:0] mem_wdata;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = en & ~loop & ~full;
    assign out_valid = en & ~empty;
    assign push      = bus.in_valid & in_ready;
    assign pop       = out_valid & bus.out_ready;

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid;
    assign bus.out_data     = out_valid ? mem[rd_ptr_q] : '0;
    assign bus.count        = count_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= CW'(AFULL_LVL));
    assign bus.almost_empty = (count_q <= CW'(AEMPTY_LVL));

    // push and loop-pop are mutually exclusive because in_ready is low in loop mode
    assign mem_we    = ~rst & ~flush & (push | (loop & pop));
    assign mem_wdata = push ? bus.in_data : mem[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (loop) begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; flush and rst only clear the bookkeeping.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= mem_wdata;
        end
    end
endmodule

// File: tb/tb_stream_fifo.sv
// Randomised and directed bench for stream_fifo, checked every cycle against a queue model.
module tb_stream_fifo;
    localparam int unsigned WIDTH = 2;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AFULL = 6;
    localparam int unsigned AEMPTY = 2;

    logic clk = 1'b0;
    logic rst, en, flush, loop;

    stream_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    stream_fifo #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .AFULL_LVL  (AFULL),
        .AEMPTY_LVL (AEMPTY)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .flush (flush),
        .loop  (loop),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] model_q  [$];
    logic [WIDTH-1:0] popped_q [$];
    bit   model_known;
    int   n_checks;
    int   n_pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge with inputs already driven; checks outputs, then advances one edge.
    task automatic tick();
        int sz;
        bit do_push, do_pop;
        logic [WIDTH-1:0] w;
        #1;
        sz = model_q.size();
        if (model_known) begin
            check("count", 32'(bus.count), 32'(sz));
            check("full", 32'(bus.full), 32'(sz == DEPTH));
            check("empty", 32'(bus.empty), 32'(sz == 0));
            check("almost_full", 32'(bus.almost_full), 32'(sz >= AFULL));
            check("almost_empty", 32'(bus.almost_empty), 32'(sz <= AEMPTY));
            check("in_ready", 32'(bus.in_ready), 32'(en && !loop && sz != DEPTH));
            check("out_valid", 32'(bus.out_valid), 32'(en && sz != 0));
            check("out_data", 32'(bus.out_data), (en && sz != 0) ? 32'(model_q[0]) : 32'd0);
        end
        @(posedge clk);
        do_pop  = en && bus.out_ready && sz != 0;
        do_push = en && !loop && bus.in_valid && sz != DEPTH;
        if (rst || flush) begin
            model_q.delete();
            model_known = 1'b1;
        end else if (en) begin
            if (do_pop) begin
                w = model_q.pop_front();
                popped_q.push_back(w);
                if (loop) model_q.push_back(w);
            end
            if (do_push) model_q.push_back(bus.in_data);
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit iv, input int d, input bit ordy);
        bus.in_valid  = iv;
        bus.in_data   = WIDTH'(d);
        bus.out_ready = ordy;
        tick();
    endtask

    task automatic idle_inputs();
        rst = 0; flush = 0; en = 1; loop = 0;
        bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
    endtask

    task automatic load(input int n, input int base);
        for (int i = 0; i < n; i++) drive(1, base + i, 0);
        drive(0, 0, 0);
    endtask

    task automatic clear();
        flush = 1; drive(0, 0, 0); flush = 0;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; model_known = 0;
        idle_inputs();
        rst = 1;
        @(negedge clk);
        tick();
        rst = 0;
        drive(0, 0, 0);

        // Fill with 0,1,2,3,0,1,2,3 then offer a 9th word
        for (int i = 0; i < 8; i++) drive(1, i % 4, 0);
        drive(1, 2, 0);
        check("fill_count", 32'(bus.count), 32'd8);

        // Drain and check order
        popped_q.delete();
        for (int i = 0; i < 9; i++) drive(0, 0, 1);
        check("drain_len", 32'(popped_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < popped_q.size(); i++)
            check("drain_order", 32'(popped_q[i]), 32'(i % 4));

        // Simultaneous push/pop at count 4
        load(4, 0);
        for (int i = 0; i < 20; i++) drive(1, i + 4, 1);
        check("simul_count", 32'(bus.count), 32'd4);
        popped_q.delete();
        for (int i = 0; i < 5; i++) drive(0, 0, 1);
        check("simul_tail_len", 32'(popped_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < popped_q.size(); i++)
            check("simul_tail", 32'(popped_q[i]), 32'((i + 20) % 4));

        // Loop replay of 3,2,1
        clear();
        drive(1, 3, 0); drive(1, 2, 0); drive(1, 1, 0);
        loop = 1;
        popped_q.delete();
        for (int i = 0; i < 9; i++) drive(1, 0, 1);
        check("loop_len", 32'(popped_q.size()), 32'd9);
        for (int i = 0; i < 9 && i < popped_q.size(); i++)
            check("loop_order", 32'(popped_q[i]), 32'(3 - (i % 3)));
        loop = 0;
        drive(0, 0, 0);

        // Flush, then rst, together with push and pop at count 5
        clear(); load(5, 1);
        flush = 1; drive(1, 2, 1); flush = 0;
        check("flush_count", 32'(bus.count), 32'd0);
        drive(0, 0, 0);
        load(5, 1);
        rst = 1; drive(1, 2, 1); rst = 0;
        check("rst_count", 32'(bus.count), 32'd0);
        load(3, 0);
        en = 0; rst = 1; drive(0, 0, 0); rst = 0; en = 1;
        check("rst_en0_empty", 32'(bus.empty), 32'd1);

        // Enable freeze at count 3
        load(3, 2);
        en = 0;
        for (int i = 0; i < 5; i++) drive(1, i, 1);
        check("freeze_count", 32'(bus.count), 32'd3);
        en = 1;
        for (int i = 0; i < 6; i++) drive(1, i, 1);
        for (int i = 0; i < 4; i++) drive(0, 0, 1);

        // Random traffic with occasional mode changes, stalls and clears
        for (int i = 0; i < 600; i++) begin
            en    = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 49) == 0);
            rst   = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 19) == 0) loop = ~loop;
            drive($urandom_range(0, 1), $urandom, $urandom_range(0, 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
